// File: rtl/grid_mem_arbiter.sv
// Grid RAM arbiter: shares the single-port tetris grid RAM between NREQ
// requesters. Round-robin arbitration with an optional absolute-priority
// requester, lock for atomic bursts, and a lock timeout so the display
// scanout can never be starved by a stuck lock.
//
//   state | meaning
//   IDLE  | no owner, gnt=0, RAM port parked (we=0, addr/wdata=0)
//   OWN   | gnt[owner]=1, owner's request drives the RAM port this cycle
module grid_mem_arbiter #(
    parameter int NREQ     = 3,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int PRIO_EN  = 1,
    parameter int PRIO_IDX = 0,
    parameter int MAX_LOCK = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     lock_timeout,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int OWN_W = $clog2(NREQ);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);
    // An out-of-range priority index simply yields an empty mask.
    localparam logic [NREQ-1:0] PRIO_MASK =
        ((PRIO_EN != 0) && (PRIO_IDX >= 0) && (PRIO_IDX < NREQ)) ? (NREQ'(1) << PRIO_IDX) : '0;

    typedef enum logic {IDLE, OWN} state_t;

    state_t               state;
    logic [OWN_W-1:0]     owner;
    logic [OWN_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]     lock_cnt;

    logic                 own_req;
    logic                 own_lock;
    logic                 own_we;
    logic                 lock_hold;
    logic                 lock_force;
    logic [NREQ-1:0]      elig;
    logic                 any_elig;
    logic [OWN_W-1:0]     winner;
    logic [OWN_W-1:0]     rr_next;
    logic [OWN_W-1:0]     scan_sel;
    logic                 found;

    // Owner-selected view of the request bundle and the RAM port mux.
    always_comb begin
        own_req   = 1'b0;
        own_lock  = 1'b0;
        own_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == OWN) begin
            for (int i = 0; i < NREQ; i++) begin
                if (owner == OWN_W'(i)) begin
                    own_req   = req[i];
                    own_lock  = lock[i];
                    own_we    = req_we[i];
                    mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
                    mem_wdata = req_wdata[i*DATA_W +: DATA_W];
                end
            end
        end
        mem_we = own_req & own_we;
    end

    // Lock continuation vs. forced release; a forced release excludes the old owner.
    always_comb begin
        lock_hold  = own_req & own_lock & (lock_cnt < LOCK_LAST);
        lock_force = own_req & own_lock & ~(lock_cnt < LOCK_LAST);
        elig       = req;
        if (lock_force) begin
            elig = req & ~(NREQ'(1) << owner);
        end
        any_elig = |elig;
    end

    // Winner: priority requester first, otherwise first eligible from rr_ptr upward.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_sel = '0;
        if (|(elig & PRIO_MASK)) begin
            winner = OWN_W'(PRIO_IDX);
            found  = 1'b1;
        end
        for (int k = 0; k < NREQ; k++) begin
            scan_sel = OWN_W'((int'(rr_ptr) + k) % NREQ);
            if (!found && elig[scan_sel]) begin
                winner = scan_sel;
                found  = 1'b1;
            end
        end
        rr_next = OWN_W'((int'(winner) + 1) % NREQ);
    end

    assign rdata = mem_rdata;

    // Ownership FSM with registered grant, read-valid and timeout outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= '0;
            rr_ptr       <= '0;
            lock_cnt     <= '0;
            gnt          <= '0;
            rvalid       <= '0;
            lock_timeout <= 1'b0;
        end else begin
            rvalid <= '0;
            if (own_req && !own_we) begin
                rvalid[owner] <= 1'b1;
            end
            lock_timeout <= lock_force;

            if (lock_hold) begin
                lock_cnt <= lock_cnt + CNT_W'(1);
            end else if (any_elig) begin
                state    <= OWN;
                owner    <= winner;
                gnt      <= NREQ'(1) << winner;
                rr_ptr   <= rr_next;
                lock_cnt <= '0;
            end else begin
                state    <= IDLE;
                gnt      <= '0;
                lock_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Testbench for grid_mem_arbiter: directed scenarios followed by a random
// phase, all checked against a transaction-level model of the arbiter and
// a golden copy of the grid RAM.
module tb_grid_mem_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int ML   = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req, lock, req_we;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [NREQ-1:0]     gnt, rvalid;
    logic [DW-1:0]       rdata;
    logic                lock_timeout;
    logic [AW-1:0]       mem_addr;
    logic                mem_we;
    logic [DW-1:0]       mem_wdata;
    logic [DW-1:0]       mem_rdata;

    grid_mem_arbiter #(
        .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW),
        .PRIO_EN(1), .PRIO_IDX(0), .MAX_LOCK(ML)
    ) dut (
        .clk(clk), .reset(reset),
        .req(req), .lock(lock), .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .lock_timeout(lock_timeout),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Grid RAM seen by the DUT, and the golden copy the model maintains.
    logic [7:0] ram  [256];
    logic [7:0] gold [256];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int checks   = 0;
    int failures = 0;

    // Model state: current owner (-1 none), next round-robin start, cycles held.
    int          m_owner;
    int          m_rr;
    int          m_held;
    logic [2:0]  exp_gnt;
    logic [2:0]  exp_rv;
    logic [7:0]  exp_rd;
    logic        exp_lto;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] addr_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic logic [7:0] wdata_of(input int i);
        return req_wdata[i*DW +: DW];
    endfunction

    task automatic set_req(input int i, input logic r, input logic l, input logic w,
                           input logic [7:0] a, input logic [7:0] d);
        req[i]                = r;
        lock[i]               = l;
        req_we[i]             = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        req = '0; lock = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_held = 0;
        exp_gnt = '0; exp_rv = '0; exp_lto = 1'b0; exp_rd = '0;
    endtask

    // One clock of arbiter behaviour, from the rules: access by the owner,
    // then either a locked continuation or a fresh pick.
    task automatic model_step();
        logic [2:0] cand;
        int         pick;
        logic       keep;
        exp_rv  = '0;
        exp_lto = 1'b0;
        keep    = 1'b0;
        if (m_owner >= 0 && req[m_owner]) begin
            if (req_we[m_owner]) begin
                gold[addr_of(m_owner)] = wdata_of(m_owner);
            end else begin
                exp_rv[m_owner] = 1'b1;
                exp_rd          = gold[addr_of(m_owner)];
            end
        end
        cand = req;
        if (m_owner >= 0 && req[m_owner] && lock[m_owner]) begin
            if (m_held < ML) begin
                m_held = m_held + 1;
                keep   = 1'b1;
            end else begin
                exp_lto       = 1'b1;
                cand[m_owner] = 1'b0;
            end
        end
        if (!keep) begin
            pick = -1;
            if (cand[0]) pick = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (pick < 0 && cand[(m_rr + k) % NREQ]) pick = (m_rr + k) % NREQ;
            end
            if (pick < 0) begin
                m_owner = -1;
                exp_gnt = '0;
            end else begin
                m_owner = pick;
                m_rr    = (pick + 1) % NREQ;
                m_held  = 1;
                exp_gnt = 3'b001 << pick;
            end
        end
    endtask

    // Inputs are set at posedge+1; check the RAM port, advance one clock, check outputs.
    task automatic step();
        logic exp_we;
        #1;
        exp_we = (m_owner >= 0) && req[m_owner] && req_we[m_owner];
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        if (m_owner >= 0) begin
            chk("mem_addr", 32'(mem_addr), 32'(addr_of(m_owner)));
            if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(wdata_of(m_owner)));
        end else begin
            chk("mem_addr_idle", 32'(mem_addr), 32'd0);
        end
        model_step();
        @(posedge clk);
        #1;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("rvalid", 32'(rvalid), 32'(exp_rv));
        chk("lock_timeout", 32'(lock_timeout), 32'(exp_lto));
        if (exp_rv != 3'b000) chk("rdata", 32'(rdata), 32'(exp_rd));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]  = 8'(i) ^ 8'hA5;
            gold[i] = 8'(i) ^ 8'hA5;
        end
        ram[17]  = 8'h03;
        gold[17] = 8'h03;

        // Reset state
        clear_reqs();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_lto", 32'(lock_timeout), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        reset = 1'b0;

        // Single read of address 17
        set_req(1, 1'b1, 1'b0, 1'b0, 8'd17, 8'h00);
        step();
        chk("t1_gnt", 32'(gnt), 32'b010);
        step();
        chk("t1_rvalid", 32'(rvalid), 32'b010);
        chk("t1_rdata", 32'(rdata), 32'h03);
        clear_reqs();
        step();
        step();

        // Round-robin between requesters 1 and 2 (display idle)
        set_req(1, 1'b1, 1'b0, 1'b0, 8'd5, 8'h00);
        set_req(2, 1'b1, 1'b0, 1'b0, 8'd6, 8'h00);
        for (int n = 0; n < 6; n++) step();

        // Display priority, then display drops out
        set_req(0, 1'b1, 1'b0, 1'b0, 8'd7, 8'h00);
        for (int n = 0; n < 4; n++) step();
        set_req(0, 1'b0, 1'b0, 1'b0, 8'd7, 8'h00);
        for (int n = 0; n < 4; n++) step();
        clear_reqs();
        step();
        step();

        // Locked burst of writes 12..15 by requester 2 while display waits
        set_req(2, 1'b1, 1'b1, 1'b1, 8'd12, 8'h50);
        step();
        set_req(0, 1'b1, 1'b0, 1'b0, 8'd32, 8'h00);
        for (int j = 0; j < 4; j++) begin
            set_req(2, 1'b1, (j < 3) ? 1'b1 : 1'b0, 1'b1, 8'(12 + j), 8'(8'h50 + j));
            step();
            if (j < 3) chk("t4_locked_gnt", 32'(gnt), 32'b100);
        end
        chk("t4_display_gnt", 32'(gnt), 32'b001);
        set_req(2, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
        step();
        clear_reqs();
        set_req(1, 1'b1, 1'b0, 1'b0, 8'd14, 8'h00);
        step();
        step();
        chk("t4_readback", 32'(rdata), 32'h52);
        clear_reqs();
        step();
        step();

        // Lock timeout: requester 1 holds lock, requester 2 waiting
        set_req(1, 1'b1, 1'b1, 1'b0, 8'd40, 8'h00);
        set_req(2, 1'b1, 1'b0, 1'b0, 8'd41, 8'h00);
        for (int n = 0; n < 7; n++) step();
        clear_reqs();
        step();
        step();

        // Async reset in the middle of an owned access
        set_req(1, 1'b1, 1'b0, 1'b0, 8'd17, 8'h00);
        step();
        step();
        set_req(1, 1'b1, 1'b0, 1'b1, 8'd17, 8'hEE);
        #1;
        chk("t6_pre_we", 32'(mem_we), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_gnt", 32'(gnt), 32'd0);
        chk("t6_rvalid", 32'(rvalid), 32'd0);
        chk("t6_mem_we", 32'(mem_we), 32'd0);
        clear_reqs();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        step();
        set_req(1, 1'b1, 1'b0, 1'b0, 8'd17, 8'h00);
        set_req(2, 1'b1, 1'b0, 1'b0, 8'd18, 8'h00);
        step();
        chk("t6_rr_from_zero", 32'(gnt), 32'b010);
        step();
        chk("t6_ram_kept", 32'(rdata), 32'h03);
        clear_reqs();
        step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                        1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
